// File: rtl/serial_frame_controller_if.sv
// Bundles the serial line and the per-channel outputs of the serial frame controller.
// The controller uses the slave modport and the line driver or consumer uses the master modport.
interface serial_frame_controller_if #(
    parameter int ADDR_W = 2,
    parameter int LEN_W  = 8
);
    logic                   serial_in;
    logic                   serial_out;
    logic [2**ADDR_W-1:0]   ch_valid;
    logic                   wake_em_up;
    logic                   done;
    logic                   busy;
    logic [ADDR_W-1:0]      cur_addr;
    logic [LEN_W-1:0]       cur_len;

    modport master (
        output serial_in,
        input  serial_out,
        input  ch_valid,
        input  wake_em_up,
        input  done,
        input  busy,
        input  cur_addr,
        input  cur_len
    );

    modport slave (
        input  serial_in,
        output serial_out,
        output ch_valid,
        output wake_em_up,
        output done,
        output busy,
        output cur_addr,
        output cur_len
    );
endinterface

// File: rtl/serial_frame_controller.sv
// Receives one serial frame (start, address, length, payload) and steers the payload
// to the addressed channel. It also counts the payload down and pulses done when the frame ends.
module serial_frame_controller #(
    parameter int ADDR_W = 2,
    parameter int LEN_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_frame_controller_if.slave bus
);
    localparam int MAX_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        PAYLOAD,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_next;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_next;
    logic [LEN_W-1:0]  len_shift;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  remaining_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= '0;
            len       <= '0;
            remaining <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_next;
            addr      <= addr_next;
            len       <= len_next;
            remaining <= remaining_next;
            bit_cnt   <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        addr_next      = addr;
        len_next       = len;
        remaining_next = remaining;
        bit_cnt_next   = bit_cnt;
        len_shift      = (len << 1) | LEN_W'(bus.serial_in);

        case (state)
            IDLE: begin
                if (!bus.serial_in) begin
                    state_next   = ADDR;
                    bit_cnt_next = '0;
                end
            end
            ADDR: begin
                addr_next = (addr << 1) | ADDR_W'(bus.serial_in);
                if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                    state_next   = LEN;
                    bit_cnt_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            LEN: begin
                len_next = len_shift;
                if (bit_cnt == CNT_W'(LEN_W - 1)) begin
                    bit_cnt_next = '0;
                    if (len_shift == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next     = PAYLOAD;
                        remaining_next = len_shift;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            PAYLOAD: begin
                // Exiting at remaining <= 1 keeps the down-counter from ever wrapping past zero.
                if (remaining <= LEN_W'(1)) begin
                    state_next     = DONE;
                    remaining_next = '0;
                end else begin
                    remaining_next = remaining - LEN_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        bus.ch_valid = '0;
        if (state == PAYLOAD) begin
            bus.ch_valid[addr] = 1'b1;
        end
        bus.serial_out = bus.serial_in & (state == PAYLOAD);
        bus.wake_em_up = (state == PAYLOAD) && (remaining == LEN_W'(1));
        bus.done       = (state == DONE);
        bus.busy       = (state != IDLE);
        bus.cur_addr   = addr;
        bus.cur_len    = len;
    end
endmodule

// File: doc/serial_frame_controller.md
Name: serial_frame_controller

Overview:
- Sequences one serial frame on `serial_in` and steers its payload to one of N output channels.
- Frame format, one bit per clock: start bit (0), then port address (ADDR_W bits, MSB first), then payload length (LEN_W bits, MSB first), then exactly `length` payload bits.
- Replaces the free-standing load/count-down post stage: the controller itself captures the length, counts the payload down, and drives per-channel valid, a last-bit wake pulse and a frame-done pulse.
- Sits between the serial line input and the per-port consumers.

Parameters:
- ADDR_W, 2, width of the port address field; channel count N = 2**ADDR_W.
- LEN_W, 8, width of the payload length field; maximum payload is 2**LEN_W-1 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- serial_in  input  1  serial line; idles high.
- serial_out  output  1  payload bit; equals serial_in while in PAYLOAD, otherwise 0.
- ch_valid  output  2**ADDR_W  one-hot; bit[addr] = 1 while in PAYLOAD, otherwise all 0.
- wake_em_up  output  1  1 during the last payload bit (remaining == 1).
- done  output  1  one-cycle pulse after the frame completes.
- busy  output  1  1 in every state except IDLE.
- cur_addr  output  ADDR_W  captured address; holds until the next frame's address capture.
- cur_len  output  LEN_W  captured length; holds until the next frame's length capture.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; addr, len, remaining and bit_cnt registers = 0.
  - Outputs: ch_valid = 0, serial_out = 0, wake_em_up = 0, done = 0, busy = 0.
  - Reset mid-frame aborts the frame. No done pulse is produced.
- Output decode:
  - ch_valid, wake_em_up, done and busy are Moore decodes of registered state and counters.
  - serial_out is a combinational gate of serial_in with the PAYLOAD state; there is no added latency.
- State transitions (each step is one rising edge):
  - IDLE: serial_in == 0 sampled -> ADDR, bit_cnt = 0. serial_in == 1 -> stay in IDLE.
  - ADDR: addr = {addr[ADDR_W-2:0], serial_in}. After ADDR_W bits -> LEN, bit_cnt = 0.
  - LEN: len = {len[LEN_W-2:0], serial_in}.
  - On the final LEN bit, the assembled length value is L:
    - L == 0 -> DONE (no PAYLOAD cycles, ch_valid never asserts).
    - L != 0 -> PAYLOAD, remaining = L.
  - PAYLOAD: remaining decrements each cycle.
    - While remaining == 1: wake_em_up = 1, and the next state is DONE.
  - DONE: done = 1 for exactly one cycle -> IDLE.
    - serial_in is ignored in DONE; start-bit detection happens only in IDLE.
- Frame timing (start bit sampled at cycle 0):
  - Address bits at cycles 1..ADDR_W.
  - Length bits at the next LEN_W cycles.
  - Payload occupies L cycles.
  - done asserts on the following cycle; IDLE is re-entered one cycle later.
- Minimum gap between frames is 1 IDLE cycle. A start bit may be sampled in the first IDLE cycle after DONE.
- Arithmetic rules:
  - remaining is LEN_W bits wide and never wraps. A decrement from 1 always exits to DONE.
  - L = 2**LEN_W-1 is legal.
- Captured values:
  - cur_addr and cur_len expose the addr and len registers.
  - They are updated during shifting and are stable throughout PAYLOAD and DONE.

Test Plan:
- Address and payload steering (ADDR_W = 2, LEN_W = 8): rst pulse, then serial_in = 1 for 3 cycles. Then drive start 0, addr 1,0, len 00000011, payload 1,0,1. Required:
  - ch_valid = 0100 for exactly 3 cycles (cycles 11..13), serial_out = 1,0,1 on those cycles.
  - wake_em_up = 1 on cycle 13 only; done = 1 on cycle 14.
  - busy = 0 on cycle 15; cur_addr = 2, cur_len = 3.
- Zero-length frame: start, addr 11, len 00000000. Required: ch_valid stays 0 throughout; done = 1 on cycle 11; wake_em_up never asserts.
- Single-bit frame (addr 00, len 1, payload 0). Required: one PAYLOAD cycle with ch_valid = 0001, serial_out = 0 and wake_em_up = 1 together; done on the next cycle.
- Maximum-length frame (len 255, addr 01). Required: ch_valid[1] high for exactly 255 cycles; wake_em_up on the 255th cycle only; no wrap, no extra cycle.
- Back-to-back frames:
  - serial_in held 0 during DONE -> no new frame starts.
  - serial_in = 0 in the first IDLE cycle -> new frame starts; cur_addr and cur_len update correctly.
- Asynchronous reset mid-PAYLOAD (rst = 0 between clock edges). Required:
  - ch_valid, serial_out and busy drop to 0 immediately; no done pulse.
  - After release with serial_in = 1 the block stays in IDLE, then accepts a new frame normally.
